vec3_length_seq: RTL and testbench

Multi-cycle, parametrised vector magnitude unit. It computes |v| = sqrt(x²+y²+z²) for a signed fixed-point 3-vector using a Newton-Raphson inverse square root on a single shared multiplier. On request it also returns the unit vector v/|v|. It sits between the ray-march step logic and the shading and normalisation stages, behind a valid/ready handshake on both sides.

---
 rtl/vector_pkg.sv | 42 ++++
 rtl/lead_one_detect.sv | 19 +
 rtl/vec3_length_seq.sv | 205 ++++++++++++++++++++
 tb/tb_vec3_length_seq.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and fixed-point helpers for the vector datapath units.
package vector_pkg;

  typedef enum logic [2:0] {
    IDLE, SQ, SUM, SEED, ITER, LEN, NORM, DONE
  } len_state_e;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] val;
  } mul_res_t;

  // 1.5 in Q.frac format
  function automatic logic signed [63:0] FP_THREE_HALVES(input int unsigned frac);
    return 64'sd3 <<< (frac - 1);
  endfunction

  // Signed fixed-point multiply: floor shift, symmetric saturation to +/-(2^(n-1)-1)
  function automatic mul_res_t fp_mul_sat(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int unsigned        n,
                                          input int unsigned        frac);
    logic signed [63:0] prod;
    logic signed [63:0] sh;
    logic signed [63:0] lim;
    mul_res_t           r;
    prod  = a * b;
    sh    = prod >>> frac;
    lim   = (64'sd1 <<< (n - 1)) - 64'sd1;
    r.sat = 1'b0;
    r.val = sh;
    if (sh > lim) begin
      r.val = lim;
      r.sat = 1'b1;
    end else if (sh < -lim) begin
      r.val = -lim;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lead_one_detect.sv
// Priority encoder: index of the most significant set bit, plus an all-zero flag.
module lead_one_detect #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]         d,
  output logic [$clog2(W)-1:0] p,
  output logic                 zero
);
  localparam int unsigned PW = $clog2(W);

  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (d[i]) p = PW'(i);
    end
    zero = (d == '0);
  end

endmodule

// File: rtl/vec3_length_seq.sv
// Sequential |v| and v/|v| using Newton-Raphson inverse square root on one shared multiplier.
module vec3_length_seq
  import vector_pkg::*;
#(
  parameter int unsigned N         = 32,
  parameter int unsigned FRAC_BITS = 24,
  parameter int unsigned NR_ITERS  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_x,
  input  logic signed [N-1:0] in_y,
  input  logic signed [N-1:0] in_z,
  input  logic                in_norm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [N-1:0] out_len,
  output logic signed [N-1:0] out_nx,
  output logic signed [N-1:0] out_ny,
  output logic signed [N-1:0] out_nz,
  output logic                out_zero,
  output logic                out_sat
);

  localparam logic signed [N-1:0] MAXV      = N'((64'sd1 <<< (N - 1)) - 64'sd1);
  localparam logic signed [N-1:0] THREE     = N'(64'sd3 <<< FRAC_BITS);
  localparam logic signed [N-1:0] HALF3     = N'(FP_THREE_HALVES(FRAC_BITS));
  localparam logic [3:0]          LAST_ITER = 4'(NR_ITERS - 1);

  len_state_e          state;
  logic [1:0]          step;
  logic [3:0]          iter;
  logic                norm;
  logic signed [N-1:0] vx, vy, vz, s, yv, t;

  logic signed [N-1:0] op_a, op_b, sel_v, h, mul_val, seed;
  logic                mul_sat, sum_ovf;
  mul_res_t            mres;
  logic [N:0]          sum_wide;
  logic [$clog2(N)-1:0] lod_p;
  logic                lod_zero;
  int                  e_c, k_c;

  lead_one_detect #(.W(N)) u_lod (.d(s), .p(lod_p), .zero(lod_zero));

  // Shared multiplier operand select
  always_comb begin
    op_a  = '0;
    op_b  = '0;
    sel_v = (step == 2'd0) ? vx : (step == 2'd1) ? vy : vz;
    h     = (t >= THREE) ? '0 : HALF3 - (t >>> 1);
    case (state)
      SQ: begin
        op_a = sel_v;
        op_b = sel_v;
      end
      ITER: begin
        case (step)
          2'd0:    begin op_a = yv; op_b = yv; end
          2'd1:    begin op_a = s;  op_b = t;  end
          default: begin op_a = yv; op_b = h;  end
        endcase
      end
      LEN: begin
        op_a = s;
        op_b = yv;
      end
      NORM: begin
        op_a = sel_v;
        op_b = yv;
      end
      default: ;
    endcase
    mres     = fp_mul_sat(64'(op_a), 64'(op_b), N, FRAC_BITS);
    mul_val  = N'(mres.val);
    mul_sat  = mres.sat;
    sum_wide = {1'b0, s} + {1'b0, mul_val};
    sum_ovf  = (sum_wide > {1'b0, MAXV});
  end

  // Power-of-two seed within a factor sqrt(2) of 1/sqrt(s)
  always_comb begin
    e_c = int'(lod_p) - int'(FRAC_BITS);
    k_c = int'(FRAC_BITS) - ((e_c + 1) >>> 1);
    if (k_c >= int'(N) - 1)  seed = MAXV;
    else if (k_c < 0)        seed = N'(1);
    else                     seed = N'(1) << k_c;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      step      <= '0;
      iter      <= '0;
      norm      <= 1'b0;
      vx        <= '0;
      vy        <= '0;
      vz        <= '0;
      s         <= '0;
      yv        <= '0;
      t         <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_len   <= '0;
      out_nx    <= '0;
      out_ny    <= '0;
      out_nz    <= '0;
      out_zero  <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vx       <= in_x;
            vy       <= in_y;
            vz       <= in_z;
            norm     <= in_norm;
            s        <= '0;
            step     <= '0;
            out_len  <= '0;
            out_nx   <= '0;
            out_ny   <= '0;
            out_nz   <= '0;
            out_zero <= 1'b0;
            out_sat  <= 1'b0;
            in_ready <= 1'b0;
            state    <= SQ;
          end
        end
        SQ: begin
          s       <= sum_ovf ? MAXV : N'(sum_wide);
          out_sat <= out_sat | mul_sat | sum_ovf;
          step    <= step + 2'd1;
          if (step == 2'd2) begin
            step  <= '0;
            state <= SUM;
          end
        end
        SUM: begin
          if (lod_zero) begin
            out_zero <= 1'b1;
            state    <= LEN;
          end else begin
            state <= SEED;
          end
        end
        SEED: begin
          yv    <= seed;
          iter  <= '0;
          step  <= '0;
          state <= ITER;
        end
        ITER: begin
          if (step == 2'd2) yv <= mul_val;
          else              t  <= mul_val;
          out_sat <= out_sat | mul_sat;
          step    <= step + 2'd1;
          if (step == 2'd2) begin
            step <= '0;
            iter <= iter + 4'd1;
            if (iter == LAST_ITER) state <= LEN;
          end
        end
        LEN: begin
          if (!out_zero) begin
            out_len <= mul_val;
            out_sat <= out_sat | mul_sat;
          end
          if (norm && !out_zero) begin
            step  <= '0;
            state <= NORM;
          end else begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        NORM: begin
          case (step)
            2'd0:    out_nx <= mul_val;
            2'd1:    out_ny <= mul_val;
            default: out_nz <= mul_val;
          endcase
          out_sat <= out_sat | mul_sat;
          step    <= step + 2'd1;
          if (step == 2'd2) begin
            step      <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec3_length_seq.sv
// Random and directed checks of vec3_length_seq against a real-arithmetic reference model.
module tb_vec3_length_seq;

  localparam int N = 32;
  localparam int F = 24;
  localparam int K = 5;
  localparam longint MAXV = 64'sd2147483647;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_norm;
  logic [N-1:0] in_x, in_y, in_z;
  logic         out_valid, out_ready, out_zero, out_sat;
  logic [N-1:0] out_len, out_nx, out_ny, out_nz;

  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;

  typedef struct {
    longint x, y, z;
    bit     norm;
    longint acc;
  } req_t;
  req_t q[$];
  bit   seen_valid  = 1'b0;
  bit   expect_idle = 1'b0;

  vec3_length_seq #(.N(N), .FRAC_BITS(F), .NR_ITERS(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_norm(in_norm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_len(out_len), .out_nx(out_nx), .out_ny(out_ny), .out_nz(out_nz),
    .out_zero(out_zero), .out_sat(out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input real act, input real exp, input real tol);
    real d;
    checks++;
    d = act - exp;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0.1f, expected %0.1f +/- %0.1f", name, act, exp, tol);
    end
  endtask

  // Saturating truncated squares and saturating sum, in raw LSB units
  function automatic void model(input longint x, input longint y, input longint z,
                                output longint s, output bit sat);
    longint c[3];
    longint sq;
    c   = '{x, y, z};
    s   = 0;
    sat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sq = (c[i] * c[i]) >>> F;
      if (sq > MAXV) begin sq = MAXV; sat = 1'b1; end
      s = s + sq;
      if (s > MAXV) begin s = MAXV; sat = 1'b1; end
    end
  endfunction

  function automatic int exp_latency(input longint s, input bit norm);
    if (s == 0) return 5;
    return 6 + 3 * K + (norm ? 3 : 0);
  endfunction

  task automatic check_out(input req_t r);
    longint s;
    bit     sat;
    real    rt, scale, len_exp, tol;
    model(r.x, r.y, r.z, s, sat);
    chk_int("zero_flag", longint'(out_zero), longint'(s == 0));
    chk_int("sat_flag", longint'(out_sat), longint'(sat));
    if (s == 0) begin
      chk_int("len_zero", longint'($signed(out_len)), 0);
      chk_int("nx_zero", longint'($signed(out_nx)), 0);
      chk_int("ny_zero", longint'($signed(out_ny)), 0);
      chk_int("nz_zero", longint'($signed(out_nz)), 0);
    end else begin
      rt      = $sqrt(real'(s));
      scale   = $sqrt(2.0 ** F);
      len_exp = rt * scale;
      tol     = (len_exp / 16384.0 > 16.0) ? len_exp / 16384.0 : 16.0;
      chk_tol("len", real'($signed(out_len)), len_exp, tol);
      if (!r.norm) begin
        chk_int("nx_off", longint'($signed(out_nx)), 0);
        chk_int("ny_off", longint'($signed(out_ny)), 0);
        chk_int("nz_off", longint'($signed(out_nz)), 0);
      end else if (!sat) begin
        chk_tol("nx", real'($signed(out_nx)), real'(r.x) * scale / rt, 32.0);
        chk_tol("ny", real'($signed(out_ny)), real'(r.y) * scale / rt, 32.0);
        chk_tol("nz", real'($signed(out_nz)), real'(r.z) * scale / rt, 32.0);
      end
    end
  endtask

  // Compare process: tracks accepted requests and checks every valid output cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      seen_valid  = 1'b0;
      expect_idle = 1'b0;
    end else begin
      if (expect_idle) begin
        chk_int("turnaround_in_ready", longint'(in_ready), 1);
        chk_int("turnaround_out_valid", longint'(out_valid), 0);
        expect_idle = 1'b0;
      end
      if (out_valid) begin
        chk_int("valid_has_request", longint'(q.size() > 0), 1);
        if (q.size() > 0) begin
          if (!seen_valid) begin
            longint s0;
            bit     sat0;
            model(q[0].x, q[0].y, q[0].z, s0, sat0);
            chk_int("latency", cyc - q[0].acc, longint'(exp_latency(s0, q[0].norm)));
            seen_valid = 1'b1;
          end
          check_out(q[0]);
          chk_int("ready_while_valid", longint'(in_ready), 0);
          if (out_ready) begin
            void'(q.pop_front());
            seen_valid  = 1'b0;
            expect_idle = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) begin
        req_t r;
        r.x = longint'($signed(in_x));
        r.y = longint'($signed(in_y));
        r.z = longint'($signed(in_z));
        r.norm = in_norm;
        r.acc = cyc + 1;
        q.push_back(r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint x, input longint y, input longint z, input bit nm,
                      output longint acc);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk_int("ready_wait", longint'(in_ready), 1);
    in_x     = 32'(x);
    in_y     = 32'(y);
    in_z     = 32'(z);
    in_norm  = nm;
    in_valid = 1'b1;
    tick();
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output longint lat, input longint acc);
    int n;
    n = 0;
    while (!out_valid && n < 60) begin tick(); n++; end
    chk_int("valid_wait", longint'(out_valid), 1);
    lat = cyc - acc;
  endtask

  task automatic release_result(input int hold);
    repeat (hold) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_int("release_in_ready", longint'(in_ready), 1);
  endtask

  function automatic longint rnd(input longint r);
    if ($urandom_range(0, 3) == 0) return 0;
    return longint'($urandom_range(0, 32'(2 * r))) - r;
  endfunction

  localparam longint ONE = 64'sd1 << F;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint acc, lat, x, y, z, s, r;
    bit     sat, nm;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_norm = 1'b0;
    in_x = '0; in_y = '0; in_z = '0;
    repeat (3) tick();
    chk_int("rst_in_ready", longint'(in_ready), 1);
    chk_int("rst_out_valid", longint'(out_valid), 0);
    chk_int("rst_out_len", longint'(out_len), 0);
    chk_int("rst_out_zero", longint'(out_zero), 0);
    chk_int("rst_out_sat", longint'(out_sat), 0);
    rst_n = 1'b1;
    tick();

    // (3,4,0) length only
    send(3 * ONE, 4 * ONE, 0, 1'b0, acc);
    wait_valid(lat, acc);
    chk_int("lat_345", lat, 21);
    chk_tol("len_345", real'($signed(out_len)), 83886080.0, 5120.0);
    chk_int("sat_345", longint'(out_sat), 0);
    release_result(0);

    // (-1,-2,2) with unit vector
    send(-ONE, -2 * ONE, 2 * ONE, 1'b1, acc);
    wait_valid(lat, acc);
    chk_int("lat_122", lat, 24);
    chk_tol("len_122", real'($signed(out_len)), 50331648.0, 3072.0);
    chk_tol("nx_122", real'($signed(out_nx)), -5592405.3, 32.0);
    chk_tol("ny_122", real'($signed(out_ny)), -11184810.7, 32.0);
    chk_tol("nz_122", real'($signed(out_nz)), 11184810.7, 32.0);
    release_result(1);

    // zero vector
    send(0, 0, 0, 1'b1, acc);
    wait_valid(lat, acc);
    chk_int("lat_zero", lat, 5);
    chk_int("zero_zero", longint'(out_zero), 1);
    chk_int("len_zero_lit", longint'(out_len), 0);
    release_result(0);

    // saturating sum
    send(100 * ONE, 100 * ONE, 100 * ONE, 1'b0, acc);
    wait_valid(lat, acc);
    chk_int("sat_big", longint'(out_sat), 1);
    chk_tol("len_big", real'($signed(out_len)), 189812531.0, 11585.0);
    release_result(2);

    // backpressure with an ignored request while busy
    send(ONE, 2 * ONE, 2 * ONE, 1'b0, acc);
    wait_valid(lat, acc);
    for (int i = 0; i < 10; i++) begin
      chk_int("bp_in_ready", longint'(in_ready), 0);
      chk_int("bp_out_valid", longint'(out_valid), 1);
      chk_tol("bp_len", real'($signed(out_len)), 50331648.0, 3072.0);
      if (i == 3) begin
        in_x = 32'(7 * ONE); in_y = 32'(7 * ONE); in_z = 32'(7 * ONE);
        in_valid = 1'b1;
      end
      if (i == 6) in_valid = 1'b0;
      tick();
    end
    out_ready = 1'b1;
    chk_int("bp_no_turnaround", longint'(in_ready), 0);
    tick();
    out_ready = 1'b0;
    chk_int("bp_ready_after", longint'(in_ready), 1);
    chk_int("bp_valid_after", longint'(out_valid), 0);

    // reset during ITER, then a fresh request
    send(5 * ONE, 0, 0, 1'b0, acc);
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk_int("midrst_out_valid", longint'(out_valid), 0);
    chk_int("midrst_in_ready", longint'(in_ready), 1);
    chk_int("midrst_out_len", longint'(out_len), 0);
    chk_int("midrst_out_nx", longint'(out_nx), 0);
    chk_int("midrst_out_sat", longint'(out_sat), 0);
    rst_n = 1'b1;
    tick();
    send(ONE, 0, 0, 1'b1, acc);
    wait_valid(lat, acc);
    chk_int("lat_unit", lat, 24);
    chk_int("len_unit", longint'($signed(out_len)), ONE);
    chk_int("nx_unit", longint'($signed(out_nx)), ONE);
    release_result(0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      nm = (i % 2 == 1);
      r  = nm ? 2 * ONE : 6 * ONE;
      do begin
        x = rnd(r); y = rnd(r); z = rnd(r);
        model(x, y, z, s, sat);
      end while (s < (64'sd1 << 20));
      send(x, y, z, nm, acc);
      wait_valid(lat, acc);
      release_result(int'($urandom_range(0, 3)));
    end

    repeat (3) tick();
    chk_int("queue_drained", longint'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
